// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder: ALUOP classes, 4-bit ALU
// operation codes and the unsupported-encoding classifier.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_BEQ  = 4'b1000;
  localparam logic [3:0] ALU_BNE  = 4'b1001;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_BLT  = 4'b1100;
  localparam logic [3:0] ALU_BGE  = 4'b1101;
  localparam logic [3:0] ALU_BLTU = 4'b1110;
  localparam logic [3:0] ALU_BGEU = 4'b1111;

  // Branch funct3 010/011 and R-type funct7[5]=1 other than SUB/SRA are unsupported.
  function automatic logic illegal_enc(input logic [1:0] aluop,
                                       input logic       funct7_bit2,
                                       input logic [2:0] funct3);
    logic ill_s;
    ill_s = 1'b0;
    case (aluop)
      ALUOP_BRANCH: ill_s = (funct3 == 3'b010) || (funct3 == 3'b011);
      ALUOP_RTYPE:  ill_s = funct7_bit2 && (funct3 != 3'b000) && (funct3 != 3'b101);
      default:      ill_s = 1'b0;
    endcase
    return ill_s;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOP/funct decode into the next ALU operation code.
// The illegal flag output exists only when ALU_CTRL_ILLEGAL_EN is defined.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic       funct7_bit2,
  input  logic [2:0] funct3,
  output logic [3:0] code
`ifdef ALU_CTRL_ILLEGAL_EN
  ,
  output logic       illegal
`endif
);

  // Operation code selection per instruction class.
  always_comb begin
    code = ALU_ADD;
    case (aluop)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_BRANCH: begin
        if ((funct3 == 3'b010) || (funct3 == 3'b011)) begin
          code = ALU_ADD;
        end else begin
          code = {1'b1, funct3};
        end
      end
      ALUOP_RTYPE: begin
        if (funct7_bit2 && (funct3 == 3'b000)) begin
          code = ALU_SUB;
        end else if (funct7_bit2 && (funct3 == 3'b101)) begin
          code = ALU_SRA;
        end else begin
          code = {1'b0, funct3};
        end
      end
      ALUOP_ITYPE: begin
        // funct7[5] only matters for shifts, so ADDI never becomes SUB.
        if (funct7_bit2 && (funct3 == 3'b101)) begin
          code = ALU_SRA;
        end else begin
          code = {1'b0, funct3};
        end
      end
      default: code = ALU_ADD;
    endcase
  end

`ifdef ALU_CTRL_ILLEGAL_EN
  assign illegal = illegal_enc(aluop, funct7_bit2, funct3);
`endif

endmodule

// File: rtl/alu_control.sv
// ALU control: registered decode of ALUOP/funct fields, one cycle latency.
// Define ALU_CTRL_ILLEGAL_EN to add the registered `illegal` flag output.
module alu_control
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ALUOP,
  input  logic       funct7_bit2,
  input  logic [2:0] funct3,
  output logic [3:0] ALU_Control
`ifdef ALU_CTRL_ILLEGAL_EN
  ,
  output logic       illegal
`endif
);

  logic [3:0] code_s;
  logic [3:0] alu_control_r;

`ifdef ALU_CTRL_ILLEGAL_EN
  logic illegal_s;
  logic illegal_r;

  alu_ctrl_decode u_decode (
    .aluop       (ALUOP),
    .funct7_bit2 (funct7_bit2),
    .funct3      (funct3),
    .code        (code_s),
    .illegal     (illegal_s)
  );

  // Illegal flag register, same latency as the operation code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= illegal_s;
    end
  end

  assign illegal = illegal_r;
`else
  alu_ctrl_decode u_decode (
    .aluop       (ALUOP),
    .funct7_bit2 (funct7_bit2),
    .funct3      (funct3),
    .code        (code_s)
  );
`endif

  // Operation code register; reset forces ADD immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_control_r <= ALU_ADD;
    end else begin
      alu_control_r <= code_s;
    end
  end

  assign ALU_Control = alu_control_r;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed vector table, reset and
// latency sequences, and a random sweep against a reference model.
module tb_alu_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ALUOP;
  logic       funct7_bit2;
  logic [2:0] funct3;
  logic [3:0] ALU_Control;
  logic       ill_obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] aluop;
    logic       f7;
    logic [2:0] f3;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  typedef struct {
    logic [3:0] code;
    logic       ill;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

`ifdef ALU_CTRL_ILLEGAL_EN
  logic illegal;
  assign ill_obs = illegal;
  alu_control dut (
    .clk         (clk),
    .rst         (rst),
    .ALUOP       (ALUOP),
    .funct7_bit2 (funct7_bit2),
    .funct3      (funct3),
    .ALU_Control (ALU_Control),
    .illegal     (illegal)
  );
`else
  assign ill_obs = 1'b0;
  alu_control dut (
    .clk         (clk),
    .rst         (rst),
    .ALUOP       (ALUOP),
    .funct7_bit2 (funct7_bit2),
    .funct3      (funct3),
    .ALU_Control (ALU_Control)
  );
`endif

  task automatic check_code(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: ALU_Control=%b expected %b", name, act, exp);
    end
  endtask

  task automatic check_ill(input string name, input logic act, input logic exp);
`ifdef ALU_CTRL_ILLEGAL_EN
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: illegal=%b expected %b", name, act, exp);
    end
`endif
  endtask

  // Reference decode written from the operation table.
  function automatic logic [3:0] ref_code(input logic [1:0] a, input logic f7, input logic [2:0] f3);
    if (a == 2'b00) return 4'b0000;
    if (a == 2'b01) return (f3[2:1] == 2'b01) ? 4'b0000 : {1'b1, f3};
    if (f3 == 3'b101 && f7) return 4'b1011;
    if (a == 2'b10 && f3 == 3'b000 && f7) return 4'b1010;
    return {1'b0, f3};
  endfunction

  function automatic logic ref_ill(input logic [1:0] a, input logic f7, input logic [2:0] f3);
    if (a == 2'b01) return f3[2:1] == 2'b01;
    if (a == 2'b10) return f7 && !(f3 == 3'b000 || f3 == 3'b101);
    return 1'b0;
  endfunction

  // Drive one vector between edges, push its expectation, compare after the next edge.
  task automatic apply(input string name, input logic [1:0] a, input logic f7, input logic [2:0] f3,
                       input logic [3:0] code, input logic ill);
    exp_t e;
    @(negedge clk);
    ALUOP = a;
    funct7_bit2 = f7;
    funct3 = f3;
    exp_q.push_back('{code, ill, name});
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %b", name, ALU_Control);
    end else begin
      checks--;
      e = exp_q.pop_front();
      check_code(e.name, ALU_Control, e.code);
      check_ill(e.name, ill_obs, e.ill);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d expected completion", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset while a branch BGEU encoding is present: output must already be ADD.
    rst = 1'b0;
    ALUOP = 2'b01;
    funct7_bit2 = 1'b0;
    funct3 = 3'b111;
    #2;
    check_code("reset_async", ALU_Control, 4'b0000);
    check_ill("reset_async", ill_obs, 1'b0);
    @(posedge clk);
    #1;
    check_code("reset_hold_edge", ALU_Control, 4'b0000);

    @(negedge clk);
    rst = 1'b1;
    apply("reset_release_bgeu", 2'b01, 1'b0, 3'b111, 4'b1111, 1'b0);

    // Mid-cycle reset clears immediately and overrides the pending decode.
    #2;
    rst = 1'b0;
    #1;
    check_code("midcycle_reset", ALU_Control, 4'b0000);
    @(posedge clk);
    #1;
    check_code("midcycle_reset_edge", ALU_Control, 4'b0000);
    @(negedge clk);
    rst = 1'b1;

    // Illegal flag cleared by reset.
    apply("ill_before_reset", 2'b01, 1'b0, 3'b010, 4'b0000, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_ill("ill_reset_clear", ill_obs, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    vecs.push_back('{2'b00, 1'b1, 3'b111, 4'b0000, 1'b0});
    vecs.push_back('{2'b00, 1'b0, 3'b010, 4'b0000, 1'b0});
    vecs.push_back('{2'b01, 1'b0, 3'b000, 4'b1000, 1'b0});
    vecs.push_back('{2'b01, 1'b0, 3'b001, 4'b1001, 1'b0});
    vecs.push_back('{2'b01, 1'b1, 3'b010, 4'b0000, 1'b1});
    vecs.push_back('{2'b01, 1'b0, 3'b011, 4'b0000, 1'b1});
    vecs.push_back('{2'b01, 1'b0, 3'b100, 4'b1100, 1'b0});
    vecs.push_back('{2'b01, 1'b1, 3'b101, 4'b1101, 1'b0});
    vecs.push_back('{2'b01, 1'b0, 3'b110, 4'b1110, 1'b0});
    vecs.push_back('{2'b01, 1'b0, 3'b111, 4'b1111, 1'b0});
    for (int i = 0; i < 8; i++) begin
      logic [2:0] f3_v;
      f3_v = i[2:0];
      vecs.push_back('{2'b10, 1'b0, f3_v, {1'b0, f3_v}, 1'b0});
    end
    vecs.push_back('{2'b10, 1'b1, 3'b000, 4'b1010, 1'b0});
    vecs.push_back('{2'b10, 1'b1, 3'b101, 4'b1011, 1'b0});
    vecs.push_back('{2'b10, 1'b1, 3'b110, 4'b0110, 1'b1});
    vecs.push_back('{2'b10, 1'b1, 3'b001, 4'b0001, 1'b1});
    vecs.push_back('{2'b11, 1'b1, 3'b000, 4'b0000, 1'b0});
    vecs.push_back('{2'b11, 1'b1, 3'b101, 4'b1011, 1'b0});
    vecs.push_back('{2'b11, 1'b0, 3'b101, 4'b0101, 1'b0});
    vecs.push_back('{2'b11, 1'b1, 3'b111, 4'b0111, 1'b0});

    foreach (vecs[i]) begin
      apply($sformatf("vec%0d_op%b_f7%b_f3%b", i, vecs[i].aluop, vecs[i].f7, vecs[i].f3),
            vecs[i].aluop, vecs[i].f7, vecs[i].f3, vecs[i].code, vecs[i].ill);
    end

    // Latency: changing inputs between edges must not reach the output.
    apply("latency_setup", 2'b10, 1'b0, 3'b000, 4'b0000, 1'b0);
    @(negedge clk);
    funct3 = 3'b111;
    #1;
    check_code("latency_no_comb", ALU_Control, 4'b0000);
    @(posedge clk);
    #1;
    check_code("latency_after_edge", ALU_Control, 4'b0111);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] a_v;
      logic       f7_v;
      logic [2:0] f3_v;
      a_v  = 2'($urandom_range(0, 3));
      f7_v = 1'($urandom_range(0, 1));
      f3_v = 3'($urandom_range(0, 7));
      apply($sformatf("rand%0d_op%b_f7%b_f3%b", i, a_v, f7_v, f3_v),
            a_v, f7_v, f3_v, ref_code(a_v, f7_v, f3_v), ref_ill(a_v, f7_v, f3_v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
